gate_result_collector: RTL and testbench

Downstream consumer of the three-phase gate FSM's result strobes (C_out, P_out, Q_out). It samples the strobes each qualified cycle and tags every non-zero result with a 5-bit sequence number. Tagged records are buffered in a small FIFO and drained over a valid/ready handshake. Per-strobe saturating hit counters are kept for coverage and debug readback.

---
 rtl/gate_result_collector.sv | 142 ++++++++++++++
 tb/tb_gate_result_collector.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_result_collector.sv
// -----------------------------------------------------------------------------
// gate_result_collector
//
// Sits downstream of the three-phase gate FSM and collects its result strobes
// (C_out, P_out, Q_out). The strobes are sampled on every in_valid cycle, and
// each non-zero sample becomes an 8-bit record {seq[4:0], q, p, c}. The 5-bit
// sequence number advances only when a record is accepted. Records are held in
// a small circular FIFO and drained over a valid/ready handshake. Each strobe
// also has a saturating hit counter for coverage and debug readback.
//
// Parameters:
//   DEPTH  FIFO entries; must be a power of two in the range 2..16
//   CNT_W  width of each hit counter
//
// Ports:
//   clk        clock; all state updates happen on the rising edge
//   rst        synchronous active-high reset
//   in_valid   c_in/p_in/q_in are meaningful this cycle
//   c_in       AND-phase result
//   p_in       OR-phase result
//   q_in       NAND-phase result
//   out_ready  downstream accepts the head record this cycle
//   out_valid  FIFO is non-empty, so out_data is valid
//   out_data   head record {seq, q, p, c}
//   full       FIFO holds DEPTH entries
//   empty      FIFO holds no entries
//   overflow   sticky flag: at least one record was dropped since reset
//   c_count, p_count, q_count  saturating hit counters
//   out_parity XOR of out_data; 0 while out_valid=0
//              (present only when GATE_RESULT_COLLECTOR_PARITY_EN is defined)
//
// Optional feature macro: GATE_RESULT_COLLECTOR_PARITY_EN
// -----------------------------------------------------------------------------
module gate_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             c_in,
  input  logic             p_in,
  input  logic             q_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [CNT_W-1:0] c_count,
  output logic [CNT_W-1:0] p_count,
  output logic [CNT_W-1:0] q_count
`ifdef GATE_RESULT_COLLECTOR_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occupancy;
  logic [4:0]    seq;

  logic push_req;
  logic pop;
  logic push;
  logic drop;

  // Saturating increment: the counter stops at its all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             hit);
    if (hit && (cnt != '1)) return cnt + 1'b1;
    return cnt;
  endfunction

  // Status flags come straight from the registered occupancy, so there is no
  // combinational path from the inputs to any output.
  assign empty     = (occupancy == '0);
  assign full      = (occupancy == OW'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  assign push_req = in_valid && (c_in || p_in || q_in);
  assign pop      = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

`ifdef GATE_RESULT_COLLECTOR_PARITY_EN
  assign out_parity = out_valid & (^out_data);
`endif

  // NOTE: storage is deliberately left out of reset. The occupancy counter
  // decides what is valid, and leaving the RAM unreset lets it map to
  // plain memory.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {seq, q_in, p_in, c_in};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments. Every register
  // then sees the pre-edge values of the others, which is what lets a push and
  // a pop in the same cycle work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      seq       <= '0;
      overflow  <= 1'b0;
      c_count   <= '0;
      p_count   <= '0;
      q_count   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        seq    <= seq + 5'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
      // The counters track upstream activity, whether or not the record fits.
      c_count <= sat_inc(c_count, in_valid && c_in);
      p_count <= sat_inc(p_count, in_valid && p_in);
      q_count <= sat_inc(q_count, in_valid && q_in);
    end
  end

endmodule

// File: tb/tb_gate_result_collector.sv
// -----------------------------------------------------------------------------
// tb_gate_result_collector
//
// Self-checking bench for gate_result_collector (DEPTH=4, CNT_W=8). A
// behavioural model made of a record queue, an integer sequence number and
// integer counters is advanced on every clock edge. After each edge, a snapshot
// of the DUT outputs is compared with the snapshot the model predicts. The
// scenario tasks add fixed expected values for the documented cases.
// -----------------------------------------------------------------------------
module tb_gate_result_collector;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             c_in;
  logic             p_in;
  logic             q_in;
  logic             out_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [CNT_W-1:0] c_count;
  logic [CNT_W-1:0] p_count;
  logic [CNT_W-1:0] q_count;
`ifdef GATE_RESULT_COLLECTOR_PARITY_EN
  logic             out_parity;
`endif

  gate_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .c_in      (c_in),
    .p_in      (p_in),
    .q_in      (q_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .c_count   (c_count),
    .p_count   (p_count),
    .q_count   (q_count)
`ifdef GATE_RESULT_COLLECTOR_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  int         m_seq;
  int         m_cc;
  int         m_pc;
  int         m_qc;
  bit         m_ovf;

  typedef struct packed {
    logic             valid;
    logic [7:0]       data;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             par;
    logic [CNT_W-1:0] cc;
    logic [CNT_W-1:0] pc;
    logic [CNT_W-1:0] qc;
  } snap_t;

  function automatic void model_edge(input bit r, input bit iv, input bit c,
                                     input bit p, input bit q, input bit rdy);
    bit do_pop;
    bit req;
    if (r) begin
      mq.delete();
      m_seq = 0; m_cc = 0; m_pc = 0; m_qc = 0; m_ovf = 0;
      return;
    end
    do_pop = (mq.size() > 0) && rdy;
    req    = iv && (c || p || q);
    if (iv && c && m_cc < CMAX) m_cc++;
    if (iv && p && m_pc < CMAX) m_pc++;
    if (iv && q && m_qc < CMAX) m_qc++;
    if (req && !(mq.size() < DEPTH || do_pop)) m_ovf = 1;
    if (do_pop) void'(mq.pop_front());
    if (req && m_ovf == m_ovf && (mq.size() < DEPTH)) begin
      mq.push_back(8'((m_seq << 3) | (int'(q) << 2) | (int'(p) << 1) | int'(c)));
      m_seq = (m_seq + 1) % 32;
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.valid    = mq.size() > 0;
    s.data     = (mq.size() > 0) ? mq[0] : 8'h00;
    s.full     = mq.size() == DEPTH;
    s.empty    = mq.size() == 0;
    s.overflow = m_ovf;
`ifdef GATE_RESULT_COLLECTOR_PARITY_EN
    s.par      = (mq.size() > 0) ? ^mq[0] : 1'b0;
`else
    s.par      = 1'b0;
`endif
    s.cc       = CNT_W'(m_cc);
    s.pc       = CNT_W'(m_pc);
    s.qc       = CNT_W'(m_qc);
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.valid    = out_valid;
    s.data     = out_valid ? out_data : 8'h00;
    s.full     = full;
    s.empty    = empty;
    s.overflow = overflow;
`ifdef GATE_RESULT_COLLECTOR_PARITY_EN
    s.par      = out_parity;
`else
    s.par      = 1'b0;
`endif
    s.cc       = c_count;
    s.pc       = p_count;
    s.qc       = q_count;
    return s;
  endfunction

  // Drive one cycle: inputs are applied away from the edge, the model follows
  // the edge, and outputs settle #1 after it.
  task automatic cycle(input bit r, input bit iv, input bit c, input bit p,
                       input bit q, input bit rdy);
    rst = r; in_valid = iv; c_in = c; p_in = p; q_in = q; out_ready = rdy;
    @(posedge clk);
    model_edge(r, iv, c, p, q, rdy);
    #1;
  endtask

  task automatic apply_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    snap_t o, e;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 0, i[0]);
      o = dut_snap(); e = model_snap(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    checks++;
    if ({out_valid, empty, full, overflow} !== 4'b0100 || c_count !== '0) begin
      errors++;
      $display("FAIL reset_flags got v/e/f/o=%b%b%b%b cc=%0d exp 0100 cc=0",
               out_valid, empty, full, overflow, c_count);
    end
  endtask

  task automatic test_single();
    apply_reset();
    cycle(0, 1, 1, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      errors++;
      $display("FAIL single_head got v=%b d=%h exp v=1 d=01", out_valid, out_data);
    end
    cycle(0, 0, 0, 0, 0, 1);
    checks++;
    if (empty !== 1'b1 || c_count !== CNT_W'(1) || dut_snap() !== model_snap()) begin
      errors++;
      $display("FAIL single_drain got empty=%b cc=%0d exp empty=1 cc=1", empty, c_count);
    end
  endtask

  task automatic test_zero_filter();
    snap_t o, e;
    apply_reset();
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 0);
    o = dut_snap(); e = model_snap(); checks++;
    if (o !== e || c_count !== 8'd1 || p_count !== 8'd0 || q_count !== 8'd1
        || out_data !== 8'h01) begin
      errors++;
      $display("FAIL zero_filter got=%h exp=%h", o, e);
    end
    cycle(0, 0, 0, 0, 0, 1);
    checks++;
    if (out_data !== 8'h0C || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_filter_second got v=%b d=%h exp v=1 d=0c", out_valid, out_data);
    end
  endtask

  task automatic test_full_overflow();
    logic [7:0] exp_rec [4];
    exp_rec[0] = 8'h02; exp_rec[1] = 8'h0A; exp_rec[2] = 8'h12; exp_rec[3] = 8'h1A;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 1, 0, 0);
      checks++;
      if (full !== (i >= 3) || overflow !== (i == 4)) begin
        errors++;
        $display("FAIL fill push=%0d got full=%b ovf=%b exp full=%b ovf=%b",
                 i + 1, full, overflow, i >= 3, i == 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_rec[i]) begin
        errors++;
        $display("FAIL drain idx=%0d got d=%h exp d=%h", i, out_data, exp_rec[i]);
      end
      cycle(0, 0, 0, 0, 0, 1);
    end
    cycle(0, 1, 0, 1, 0, 0);
    checks++;
    if (out_data !== 8'h22 || overflow !== 1'b1 || dut_snap() !== model_snap()) begin
      errors++;
      $display("FAIL post_overflow got d=%h ovf=%b exp d=22 ovf=1", out_data, overflow);
    end
  endtask

  task automatic test_push_pop_full();
    snap_t o, e;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      int v;
      v = $urandom_range(1, 7);
      cycle(0, 1, v[0], v[1], v[2], 0);
    end
    cycle(0, 1, 0, 0, 1, 1);
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_full got full=%b ovf=%b exp full=1 ovf=0", full, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      o = dut_snap(); e = model_snap(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL push_pop_drain idx=%0d got=%h exp=%h", i, o, e);
      end
      if (i == 3) begin
        checks++;
        if (out_data !== 8'h24) begin
          errors++;
          $display("FAIL push_pop_order got d=%h exp d=24", out_data);
        end
      end
      cycle(0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic test_saturation_wrap();
    snap_t o, e;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(0, 1, 1, 0, 0, 1);
      o = dut_snap(); e = model_snap(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sat_stream cyc=%0d got=%h exp=%h", i, o, e);
      end
      if (i == 31 || i == 32) begin
        checks++;
        if (out_data !== ((i == 31) ? 8'hF9 : 8'h01)) begin
          errors++;
          $display("FAIL seq_wrap rec=%0d got d=%h", i, out_data);
        end
      end
    end
    checks++;
    if (c_count !== 8'd255) begin
      errors++;
      $display("FAIL saturate got cc=%0d exp cc=255", c_count);
    end
    cycle(1, 1, 1, 1, 1, 1);
    o = dut_snap(); e = model_snap(); checks++;
    if (o !== e || empty !== 1'b1 || c_count !== '0) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_back_to_back();
    snap_t o, e;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      bit r;
      bit iv;
      bit rdy;
      int s;
      r   = ($urandom_range(0, 99) == 0);
      iv  = ($urandom_range(0, 3) != 0);
      rdy = (i < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0);
      s   = $urandom_range(0, 7);
      cycle(r, iv, s[0], s[1], s[2], rdy);
      o = dut_snap(); e = model_snap(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; c_in = 1'b0; p_in = 1'b0; q_in = 1'b0;
    out_ready = 1'b0;
    m_seq = 0; m_cc = 0; m_pc = 0; m_qc = 0; m_ovf = 0;
    test_reset();
    test_single();
    test_zero_filter();
    test_full_overflow();
    test_push_pop_full();
    test_saturation_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
